// File: rtl/jk_counter_sequencer.sv
// jk_counter_sequencer
//   Sequences the J/K inputs of an external bank of WIDTH JK flip-flops that share
//   this block's clock, turning the bank into a loadable up/down counter that runs
//   to a programmed limit. Each run is LOAD -> COUNT -> DONE. Every COUNT cycle the
//   bank's Q is compared with an internally tracked expected value; the first
//   mismatch aborts the run and raises a sticky error flag.
//
// Ports
//   clock_i   rising-edge clock, shared with the JK bank
//   reset_i   synchronous, active-high reset (bank contents are not touched)
//   start_i   run request, accepted only when idle
//   up_i      direction, 1 = 0 -> limit, 0 = limit -> 0; sampled on accepted start
//   limit_i   terminal (up) or initial (down) value; sampled on accepted start
//   q_i       Q outputs of the JK bank
//   j_o/k_o   J/K inputs of the JK bank
//   busy_o    high during LOAD and COUNT
//   done_o    one-cycle pulse on successful completion
//   error_o   sticky mismatch flag, cleared by reset or an accepted start
module jk_counter_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCount,
    StDone
  } state_e;

  state_e           st_q, st_d;
  logic             up_q, up_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] t_up, t_dn, target;

  // Toggle masks from the live bank value: bit i flips when all lower bits are 1
  // (counting up) or all lower bits are 0 (counting down).
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q_i[i-1];
      t_dn[i] = t_dn[i-1] & ~q_i[i-1];
    end
  end

  assign target = up_q ? lim_q : '0;

  always_comb begin
    st_d    = st_q;
    up_d    = up_q;
    lim_d   = lim_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    j_o     = '0;
    k_o     = '0;

    unique case (st_q)
      StIdle: begin
        if (start_i) begin
          up_d    = up_i;
          lim_d   = limit_i;
          error_d = 1'b0;
          busy_d  = 1'b1;
          st_d    = StLoad;
        end
      end

      StLoad: begin
        // Parallel load through J/K: J=1,K=0 sets a bit, J=0,K=1 clears it.
        if (up_q) begin
          k_o   = '1;
          exp_d = '0;
        end else begin
          j_o   = lim_q;
          k_o   = ~lim_q;
          exp_d = lim_q;
        end
        st_d = StCount;
      end

      StCount: begin
        if (q_i != exp_q) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          st_d    = StIdle;
        end else if (q_i == target) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          st_d   = StDone;
        end else begin
          j_o   = up_q ? t_up : t_dn;
          k_o   = up_q ? t_up : t_dn;
          exp_d = up_q ? exp_q + One : exp_q - One;
        end
      end

      StDone: begin
        st_d = StIdle;
      end

      default: begin
        st_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st_q    <= StIdle;
      up_q    <= 1'b0;
      lim_q   <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      up_q    <= up_d;
      lim_q   <= lim_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = error_q;

endmodule
